// File: rtl/keyboard_event_ctrl_if.sv
// CPU data-bus view of the keyboard event controller: address, write data,
// chip select and write strobe from the CPU side, read data back from the controller.
interface keyboard_event_ctrl_if;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        enable;
  logic        MemWrite;
  logic [31:0] ReadData;

  modport master (
    output DataAdr, WriteData, enable, MemWrite,
    input  ReadData
  );

  modport slave (
    input  DataAdr, WriteData, enable, MemWrite,
    output ReadData
  );
endinterface

// File: rtl/keyboard_event_ctrl.sv
// PS/2 scan-byte sequencer (E0 extended / F0 break prefixes) feeding a key-event FIFO
// that the CPU polls and pops through STATUS/DATA/POP/CTRL word registers.
module keyboard_event_ctrl #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            code,
  input  logic                  code_valid,
  keyboard_event_ctrl_if.slave  bus,
  output logic                  irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t          state, next_state;
  logic            push;
  logic [9:0]      push_data;
  logic            is_resp;

  logic [9:0]      mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count, count_next;
  logic            overflow;

  logic [1:0]      sel;
  logic            not_empty, full;
  logic            bus_wr, do_pop, flush, clr_ovf, do_push, drop;

  logic unused_bits;
  assign unused_bits = &{1'b0, bus.DataAdr[31:4], bus.DataAdr[1:0], bus.WriteData[31:2]};

  assign is_resp = (code == 8'hAA) || (code == 8'hFA) || (code == 8'hEE) ||
                   (code == 8'hFE) || (code == 8'h00) || (code == 8'hFF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Controller response bytes abort any pending prefix; malformed double prefixes after F0 are dropped.
  always_comb begin
    next_state = state;
    push       = 1'b0;
    push_data  = 10'b0;
    if (code_valid) begin
      if (is_resp) begin
        next_state = IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (code == 8'hE0)      next_state = EXT;
            else if (code == 8'hF0) next_state = BRK;
            else begin
              push      = 1'b1;
              push_data = {2'b00, code};
            end
          end
          EXT: begin
            if (code == 8'hF0)      next_state = EXT_BRK;
            else if (code == 8'hE0) next_state = EXT;
            else begin
              push       = 1'b1;
              push_data  = {2'b10, code};
              next_state = IDLE;
            end
          end
          BRK: begin
            next_state = IDLE;
            if (code != 8'hE0 && code != 8'hF0) begin
              push      = 1'b1;
              push_data = {2'b01, code};
            end
          end
          EXT_BRK: begin
            next_state = IDLE;
            if (code != 8'hE0 && code != 8'hF0) begin
              push      = 1'b1;
              push_data = {2'b11, code};
            end
          end
          default: next_state = IDLE;
        endcase
      end
    end
  end

  assign sel       = bus.DataAdr[3:2];
  assign not_empty = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign bus_wr    = bus.enable && bus.MemWrite;
  assign flush     = bus_wr && (sel == 2'd3) && bus.WriteData[1];
  assign clr_ovf   = bus_wr && (sel == 2'd3) && bus.WriteData[0];
  assign do_pop    = bus_wr && (sel == 2'd2) && not_empty && !flush;
  // A pop in the same cycle frees the slot, so a push at full is still accepted.
  assign do_push   = push && !flush && (!full || do_pop);
  assign drop      = push && !flush && full && !do_pop;

  always_comb begin
    count_next = count;
    if (flush) count_next = '0;
    else       count_next = count + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      irq      <= 1'b0;
    end else begin
      count <= count_next;
      irq   <= (count_next != '0);
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
      end
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_comb begin
    bus.ReadData = 32'b0;
    if (bus.enable && !bus.MemWrite) begin
      case (sel)
        2'd0: begin
          bus.ReadData[0]      = not_empty;
          bus.ReadData[1]      = full;
          bus.ReadData[2]      = overflow;
          bus.ReadData[CW+7:8] = count;
        end
        2'd1: if (not_empty) bus.ReadData[9:0] = mem[rd_ptr];
        default: bus.ReadData = 32'b0;
      endcase
    end
  end

endmodule
